inst_fetch_server: RTL and testbench

Instruction-side memory responder that answers the core's fetch requests. The core issues a byte PC; this block returns the 32-bit instruction word one cycle later over a valid/ready handshake, with back-pressure and error flagging. A host-side load port writes the program image into the same storage before or between runs. It sits between the core's fetch stage and the instruction RAM.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/inst_mem_array.sv | 24 ++
 rtl/inst_fetch_server.sv | 70 +++++++
 tb/tb_inst_fetch_server.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants for the instruction fetch path
package cpu_pkg;

  localparam int          XLEN       = 32;
  localparam logic [31:0] INST_NOP   = 32'h00000013;
  localparam int          WORD_SHIFT = 2;

endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - simple dual-port synchronous RAM with registered read data
module inst_mem_array #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata holds its value whenever re is low, so a stalled response stays put.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_fetch_server.sv
// rtl/inst_fetch_server.sv - fetch responder: PC in, instruction word out one cycle later
module inst_fetch_server #(
  parameter int DEPTH = 256,
  parameter int XLEN  = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  input  logic            resp_ready,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [XLEN-1:0] ld_data,
  output logic [15:0]     ld_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int WS = cpu_pkg::WORD_SHIFT;

  logic            accept;
  logic            addr_ok;
  logic            ld_in_range;
  logic            from_mem;
  logic [XLEN-1:0] rdata;

  assign req_ready   = !ld_valid && (!resp_valid || resp_ready);
  assign accept      = req_valid && req_ready;
  assign addr_ok     = (req_addr[WS-1:0] == '0) &&
                       (req_addr[XLEN-1:WS] < (XLEN-WS)'(DEPTH));
  assign ld_in_range = ld_addr < XLEN'(DEPTH);

  inst_mem_array #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_mem (
    .clk   (clk),
    .we    (ld_valid && ld_in_range),
    .waddr (ld_addr[AW-1:0]),
    .wdata (ld_data),
    .re    (accept && addr_ok),
    .raddr (req_addr[AW+WS-1:WS]),
    .rdata (rdata)
  );

  // from_mem masks the unreset RAM output so resp_data reads 0 straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      from_mem   <= 1'b0;
      ld_count   <= '0;
    end else begin
      if (accept) begin
        resp_valid <= 1'b1;
        resp_err   <= !addr_ok;
        from_mem   <= addr_ok;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
      if (ld_valid && (ld_count != 16'hFFFF)) ld_count <= ld_count + 16'd1;
    end
  end

  assign resp_data = from_mem ? rdata : (resp_err ? XLEN'(cpu_pkg::INST_NOP) : '0);

endmodule

// File: tb/tb_inst_fetch_server.sv
// tb/tb_inst_fetch_server.sv - directed self-checking bench for inst_fetch_server
module tb_inst_fetch_server;

  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        resp_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [15:0] ld_count;

  int total = 0;
  int bad   = 0;

  inst_fetch_server #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_count   (ld_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] idx, input logic [31:0] data);
    ld_valid = 1'b1;
    ld_addr  = idx;
    ld_data  = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%0b exp=0", resp_err); end
    total++; if (ld_count !== 16'd0) begin bad++; $display("FAIL reset_ld_count got=%0d exp=0", ld_count); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    words[0] = 32'h00000093; words[1] = 32'h00100113;
    words[2] = 32'h002081B3; words[3] = 32'h0000006F;
    for (int i = 0; i < 4; i++) load(i, words[i]);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'd0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_req_ready got=%0b exp=1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) req_addr = 32'(4 * (i + 1));
      else req_valid = 1'b0;
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_data !== words[i] || resp_err !== 1'b0) begin
        bad++;
        $display("FAIL b2b_resp%0d got v=%0b d=%h e=%0b exp v=1 d=%h e=0", i, resp_valid, resp_data, resp_err, words[i]);
      end
    end
    tick();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b exp=0", resp_valid); end
    total++; if (ld_count !== 16'd4) begin bad++; $display("FAIL b2b_ld_count got=%0d exp=4", ld_count); end
  endtask

  task automatic test_stall();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'd4;
    tick();
    req_addr = 32'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h00100113 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%0b d=%h rr=%0b exp v=1 d=00100113 rr=0", i, resp_valid, resp_data, req_ready);
      end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%0b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h002081B3) begin
      bad++;
      $display("FAIL stall_next_resp got v=%0b d=%h exp v=1 d=002081b3", resp_valid, resp_data);
    end
    tick();
  endtask

  task automatic test_error();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'd6;
    tick();
    req_addr = 32'(4 * DEPTH);
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== NOP) begin
      bad++;
      $display("FAIL err_misaligned got v=%0b e=%0b d=%h exp v=1 e=1 d=%h", resp_valid, resp_err, resp_data, NOP);
    end
    tick();
    req_addr = 32'd0;
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== NOP) begin
      bad++;
      $display("FAIL err_range got v=%0b e=%0b d=%h exp v=1 e=1 d=%h", resp_valid, resp_err, resp_data, NOP);
    end
    tick();
    req_valid = 1'b0;
    #1;
    total++;
    if (resp_err !== 1'b0 || resp_data !== 32'h00000093) begin
      bad++;
      $display("FAIL err_recover got e=%0b d=%h exp e=0 d=00000093", resp_err, resp_data);
    end
    tick();
  endtask

  task automatic test_load_priority();
    resp_ready = 1'b1;
    ld_valid   = 1'b1;
    ld_addr    = 32'd1;
    ld_data    = 32'hDEADBEEF;
    req_valid  = 1'b1;
    req_addr   = 32'd4;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL ldpri_block got=%0b exp=0", req_ready); end
    tick();
    ld_valid = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL ldpri_accept got rr=%0b v=%0b exp rr=1 v=0", req_ready, resp_valid);
    end
    tick();
    req_valid = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL ldpri_data got v=%0b d=%h exp v=1 d=deadbeef", resp_valid, resp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'd4;
    tick();
    req_valid = 1'b0;
    load(32'd1, 32'h12345678);
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL pending_vs_load got v=%0b d=%h exp v=1 d=deadbeef", resp_valid, resp_data);
    end
    total++; if (ld_count !== 16'd6) begin bad++; $display("FAIL pre_reset_ld_count got=%0d exp=6", ld_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || ld_count !== 16'd0) begin
      bad++;
      $display("FAIL midstall_reset got v=%0b d=%h cnt=%0d exp v=0 d=0 cnt=0", resp_valid, resp_data, ld_count);
    end
    tick();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL no_replay got=%0b exp=0", resp_valid); end
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'd4;
    tick();
    req_addr = 32'd0;
    #1;
    total++;
    if (resp_data !== 32'h12345678) begin bad++; $display("FAIL mem_kept_1 got=%h exp=12345678", resp_data); end
    tick();
    req_valid = 1'b0;
    #1;
    total++;
    if (resp_data !== 32'h00000093) begin bad++; $display("FAIL mem_kept_0 got=%h exp=00000093", resp_data); end
    tick();
  endtask

  task automatic test_oob_load();
    load(32'd5, 32'hA5A5A5A5);
    load(32'(DEPTH + 5), 32'hFFFFFFFF);
    #1;
    total++; if (ld_count !== 16'd2) begin bad++; $display("FAIL oob_ld_count got=%0d exp=2", ld_count); end
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'd20;
    tick();
    req_valid = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hA5A5A5A5 || resp_err !== 1'b0) begin
      bad++;
      $display("FAIL oob_no_write got v=%0b d=%h e=%0b exp v=1 d=a5a5a5a5 e=0", resp_valid, resp_data, resp_err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_error();
    test_load_priority();
    test_reset_mid_stall();
    test_oob_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
